// File: rtl/speaker_i2s_tx.sv
// Stereo I2S-style transmitter: derives MCLK/SCK/LRCK from one free-running counter and
// shifts a 32-slot frame MSB first. Define SPEAKER_I2S_DELAY_EN for Philips one-slot-delay format.
module speaker_i2s_tx #(
  parameter int unsigned MCLK_LOG2 = 2,
  parameter int unsigned SCK_LOG2  = 4,
  parameter int unsigned LRCK_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        mute,
  output logic        mclk,
  output logic        sck,
  output logic        lrck,
  output logic        sdin,
  output logic        underrun
);

  localparam int unsigned CNT_W  = LRCK_LOG2;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned DATA_W = 32;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] shadow_nxt;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic              slot_end;
  logic              frame_end;
  logic              sdin_nxt;

  // Clock outputs are plain counter bits, so they cannot glitch.
  assign mclk = cnt[MCLK_LOG2-1];
  assign sck  = cnt[SCK_LOG2-1];
  assign lrck = cnt[LRCK_LOG2-1];

  assign frame_end    = &cnt;
  assign sample_ready = frame_end;
  assign slot_end     = &cnt[SCK_LOG2-1:0];
  assign slot         = SLOT_W'(cnt >> SCK_LOG2);
  assign slot_nxt     = slot + SLOT_W'(1);

  // Shadow takes the new pair on transfer; otherwise the old frame repeats.
  always_comb begin
    shadow_nxt = shadow;
    if (frame_end && sample_valid) begin
      shadow_nxt = mute ? '0 : {audio_left, audio_right};
    end
  end

`ifdef SPEAKER_I2S_DELAY_EN
  logic prev_r0;
  logic prev_r0_nxt;

  assign prev_r0_nxt = frame_end ? shadow[0] : prev_r0;

  // Slot 0 carries the last bit of the outgoing right word; the rest shift by one slot.
  always_comb begin
    sdin_nxt = sdin;
    if (slot_end) begin
      if (slot_nxt == '0) sdin_nxt = prev_r0_nxt;
      else                sdin_nxt = shadow_nxt[SLOT_W'(0) - slot_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_r0 <= 1'b0;
    else        prev_r0 <= prev_r0_nxt;
  end
`else
  // Left-justified: slot k carries shadow bit 31-k.
  always_comb begin
    sdin_nxt = sdin;
    if (slot_end) begin
      sdin_nxt = shadow_nxt[SLOT_W'(31) - slot_nxt];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      shadow   <= '0;
      sdin     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      shadow   <= shadow_nxt;
      sdin     <= sdin_nxt;
      underrun <= frame_end & ~sample_valid;
    end
  end

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// Randomized bench for speaker_i2s_tx: a frame-level model predicts every output each clk,
// and the 32 bits captured at sck rise are compared as a whole word per frame.
module tb_speaker_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_left = '0;
  logic [15:0] audio_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        mute = 1'b0;
  logic        mclk, sck, lrck, sdin, underrun;

  speaker_i2s_tx dut (
    .clk(clk), .rst_n(rst_n), .audio_left(audio_left), .audio_right(audio_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .mute(mute),
    .mclk(mclk), .sck(sck), .lrck(lrck), .sdin(sdin), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Model state
  int          n = 0;
  logic [31:0] cur_word = '0;
  logic [31:0] prev_word = '0;
  logic        exp_under = 1'b0;
  logic [31:0] ser = '0;
  logic        plan_v = 1'b0, plan_m = 1'b0;
  logic [15:0] plan_l = '0, plan_r = '0;
  logic        drv_v = 1'b0, drv_m = 1'b0;
  logic [15:0] drv_l = '0, drv_r = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Serial sequence of a frame in transmit order, slot 0 in bit 31.
  function automatic logic [31:0] frame_seq(input logic [31:0] w, input logic pr0);
`ifdef SPEAKER_I2S_DELAY_EN
    return {pr0, w[31:1]};
`else
    return w;
`endif
  endfunction

  function automatic logic slot_bit(input logic [31:0] w, input logic pr0, input int s);
    logic [31:0] q;
    q = frame_seq(w, pr0);
    return q[31 - s];
  endfunction

  task automatic tick();
    int c;
    @(posedge clk);
    #1;
    n++;
    c = n % 512;
    exp_under = 1'b0;
    if (c == 0) begin
      prev_word = cur_word;
      if (drv_v) cur_word = drv_m ? 32'h0 : {drv_l, drv_r};
      exp_under = ~drv_v;
    end
    check("mclk",     32'(mclk),         32'((c >> 1) & 1));
    check("sck",      32'(sck),          32'((c >> 3) & 1));
    check("lrck",     32'(lrck),         32'((c >> 8) & 1));
    check("ready",    32'(sample_ready), 32'(c == 511));
    check("underrun", 32'(underrun),     32'(exp_under));
    check("sdin",     32'(sdin),         32'(slot_bit(cur_word, prev_word[0], c / 16)));
    if (c % 16 == 8) ser[31 - c / 16] = sdin;
    if (c == 511) check("frame", ser, frame_seq(cur_word, prev_word[0]));
    // Only the value present at cnt=511 may matter; everything else is noise.
    if (c == 511) begin
      drv_v = plan_v; drv_m = plan_m; drv_l = plan_l; drv_r = plan_r;
      sample_valid = plan_v; mute = plan_m; audio_left = plan_l; audio_right = plan_r;
    end else begin
      sample_valid = 1'($urandom);
      mute         = 1'($urandom);
      audio_left   = 16'($urandom);
      audio_right  = 16'($urandom);
    end
  endtask

  task automatic run_frame(input logic v, input logic m, input logic [15:0] l, input logic [15:0] r);
    plan_v = v; plan_m = m; plan_l = l; plan_r = r;
    repeat (512) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mclk"},  32'(mclk),         32'h0);
    check({tag, "_sck"},   32'(sck),          32'h0);
    check({tag, "_lrck"},  32'(lrck),         32'h0);
    check({tag, "_sdin"},  32'(sdin),         32'h0);
    check({tag, "_ready"}, 32'(sample_ready), 32'h0);
    check({tag, "_under"}, 32'(underrun),     32'h0);
  endtask

  task automatic model_reset();
    n = 0; cur_word = '0; prev_word = '0; exp_under = 1'b0; ser = '0;
  endtask

  initial begin
    // Reset held 10 clk with garbage on the inputs
    sample_valid = 1'b1; audio_left = 16'hFFFF; audio_right = 16'hFFFF;
    repeat (10) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Frame 0 is zeros; A5C3/0F0F goes out in frames 1 and 2
    run_frame(1'b1, 1'b0, 16'hA5C3, 16'h0F0F);
    run_frame(1'b1, 1'b0, 16'hA5C3, 16'h0F0F);
`ifndef SPEAKER_I2S_DELAY_EN
    check("frame1_word", ser, 32'hA5C30F0F);
`endif
    // Missing sample -> underrun, A5C3/0F0F repeats in frame 3
    run_frame(1'b0, 1'b0, 16'h1234, 16'h5678);
    // Muted full-scale sample -> zero frame, no underrun
    run_frame(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    check("repeat_word", ser, frame_seq(32'hA5C30F0F, 1'b1));
    run_frame(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    check("mute_word", ser, 32'h0);

    // Random traffic
    for (int i = 0; i < 5; i++) begin
      run_frame(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                16'($urandom), 16'($urandom));
    end

    // Reset mid-frame at cnt=200
    repeat (200) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_frame(1'b1, 1'b0, 16'h8001, 16'h7FFE);
    check("post_rst_zero_frame", ser, 32'h0);
    run_frame(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("post_rst_frame1", ser, frame_seq(32'h80017FFE, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
